alarm_ctrl: RTL and testbench

- Alarm sequencer between the alarm-time setter and the timekeeping counter.
- Compares live time against the stored alarm, then drives the buzzer and LEDs.
- Handles snooze (re-target with hour/day wrap), stop, ring timeout and disarm.
- All control comes from the board switches and active-low push buttons.

---
 rtl/alarm_pkg.sv | 46 ++++
 rtl/alarm_ctrl_key_edge.sv | 31 +++
 rtl/alarm_ctrl.sv | 190 +++++++++++++++++++
 tb/tb_alarm_ctrl.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/alarm_pkg.sv
// Shared types and time constants for the alarm sequencer.
// Used by alarm_ctrl and key_edge; no configuration macros here.
package alarm_pkg;

    localparam int TIME_W        = 6;
    localparam int HOURS_PER_DAY = 24;
    localparam int MIN_PER_HOUR  = 60;

    typedef enum logic [1:0] {
        DISARMED = 2'd0,
        ARMED    = 2'd1,
        RINGING  = 2'd2,
        SNOOZING = 2'd3
    } state_t;

    typedef struct packed {
        logic [TIME_W-1:0] hour;
        logic [TIME_W-1:0] min;
    } hm_t;

    // Adds a minute offset (< 60) to hh:mm, wrapping minutes into hours and hours into the day.
    function automatic hm_t add_minutes(input logic [TIME_W-1:0] hour,
                                        input logic [TIME_W-1:0] min,
                                        input logic [6:0]        add);
        hm_t        res;
        logic [6:0] m;
        logic [TIME_W-1:0] h;
        m = {1'b0, min} + add;
        h = hour;
        if (m >= 7'(MIN_PER_HOUR)) begin
            m = m - 7'(MIN_PER_HOUR);
            h = hour + 6'd1;
        end else begin
            h = hour;
        end
        if (h == 6'(HOURS_PER_DAY)) begin
            h = 6'd0;
        end else begin
            h = h;
        end
        res.hour = h;
        res.min  = m[TIME_W-1:0];
        return res;
    endfunction

endpackage

// File: rtl/alarm_ctrl_key_edge.sv
// Push-button conditioner: 2-flop synchroniser on an active-low key plus
// falling-edge detect, giving one press pulse per press however long it is held.
module key_edge
    import alarm_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic key_n,
    output logic press
);

    logic sync1_r;
    logic sync2_r;
    logic prev_r;

    // Synchronise the raw key and keep the previous synchronised level; all flops reset to released.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_r <= 1'b1;
            sync2_r <= 1'b1;
            prev_r  <= 1'b1;
        end else begin
            sync1_r <= key_n;
            sync2_r <= sync1_r;
            prev_r  <= sync2_r;
        end
    end

    assign press = prev_r & ~sync2_r;

endmodule

// File: rtl/alarm_ctrl.sv
// Alarm sequencer: arms, rings on minute match, snoozes with day wrap, stops, times out.
// Optional macro ALARM_BEEP_PATTERN_EN pulses the buzzer 1 s on / 1 s off while ringing.
module alarm_ctrl
    import alarm_pkg::*;
#(
    parameter int unsigned SNOOZE_MIN = 5,
    parameter int unsigned MAX_SNOOZE = 3,
    parameter int unsigned RING_SEC   = 60
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              tick_1hz,
    input  logic [TIME_W-1:0] cur_hour,
    input  logic [TIME_W-1:0] cur_min,
    input  logic [TIME_W-1:0] cur_sec,
    input  logic [TIME_W-1:0] alarm_hour,
    input  logic [TIME_W-1:0] alarm_min,
    input  logic              switch_set,
    input  logic              switch_alarm,
    input  logic              key_snooze,
    input  logic              key_stop,
    output logic              buzzer,
    output logic              armed_LED,
    output logic              snooze_LED,
    output logic              ringing,
    output logic [3:0]        snooze_left
);

    localparam logic [3:0] MAX_CNT   = 4'(MAX_SNOOZE);
    localparam logic [7:0] RING_LAST = 8'(RING_SEC - 1);
    localparam logic [6:0] SNZ_ADD   = 7'(SNOOZE_MIN);

    logic snooze_press_s;
    logic stop_press_s;

    key_edge u_key_snooze (.clk(clk), .rst_n(rst_n), .key_n(key_snooze), .press(snooze_press_s));
    key_edge u_key_stop   (.clk(clk), .rst_n(rst_n), .key_n(key_stop),   .press(stop_press_s));

    state_t            state_r, state_nxt_s;
    logic [TIME_W-1:0] target_hour_r, target_hour_nxt_s;
    logic [TIME_W-1:0] target_min_r,  target_min_nxt_s;
    logic [3:0]        snooze_cnt_r,  snooze_cnt_nxt_s;
    logic [7:0]        ring_cnt_r,    ring_cnt_nxt_s;
    logic              match_s;
    logic              override_s;
    logic              buzz_nxt_s;
    hm_t               snooze_tgt_s;

    assign match_s = tick_1hz && (cur_hour == target_hour_r) &&
                     (cur_min == target_min_r) && (cur_sec == 6'd0);
    assign override_s   = !switch_alarm || switch_set;
    assign snooze_tgt_s = add_minutes(cur_hour, cur_min, SNZ_ADD);

    // Next-state and datapath decode; target follows the programmed alarm whenever not snoozing.
    always_comb begin
        state_nxt_s       = state_r;
        target_hour_nxt_s = target_hour_r;
        target_min_nxt_s  = target_min_r;
        snooze_cnt_nxt_s  = snooze_cnt_r;
        ring_cnt_nxt_s    = ring_cnt_r;
        if (override_s) begin
            state_nxt_s       = DISARMED;
            snooze_cnt_nxt_s  = 4'd0;
            ring_cnt_nxt_s    = 8'd0;
            target_hour_nxt_s = alarm_hour;
            target_min_nxt_s  = alarm_min;
        end else begin
            case (state_r)
                DISARMED: begin
                    state_nxt_s       = ARMED;
                    target_hour_nxt_s = alarm_hour;
                    target_min_nxt_s  = alarm_min;
                end
                ARMED: begin
                    target_hour_nxt_s = alarm_hour;
                    target_min_nxt_s  = alarm_min;
                    if (match_s) begin
                        state_nxt_s    = RINGING;
                        ring_cnt_nxt_s = 8'd0;
                    end else begin
                        state_nxt_s = ARMED;
                    end
                end
                RINGING: begin
                    if (stop_press_s) begin
                        state_nxt_s       = ARMED;
                        snooze_cnt_nxt_s  = 4'd0;
                        ring_cnt_nxt_s    = 8'd0;
                        target_hour_nxt_s = alarm_hour;
                        target_min_nxt_s  = alarm_min;
                    end else if (snooze_press_s && (snooze_cnt_r < MAX_CNT)) begin
                        state_nxt_s       = SNOOZING;
                        snooze_cnt_nxt_s  = snooze_cnt_r + 4'd1;
                        ring_cnt_nxt_s    = 8'd0;
                        target_hour_nxt_s = snooze_tgt_s.hour;
                        target_min_nxt_s  = snooze_tgt_s.min;
                    end else if (tick_1hz) begin
                        if (ring_cnt_r == RING_LAST) begin
                            state_nxt_s       = ARMED;
                            snooze_cnt_nxt_s  = 4'd0;
                            ring_cnt_nxt_s    = 8'd0;
                            target_hour_nxt_s = alarm_hour;
                            target_min_nxt_s  = alarm_min;
                        end else begin
                            ring_cnt_nxt_s = ring_cnt_r + 8'd1;
                        end
                    end else begin
                        state_nxt_s = RINGING;
                    end
                end
                SNOOZING: begin
                    if (stop_press_s) begin
                        state_nxt_s       = ARMED;
                        snooze_cnt_nxt_s  = 4'd0;
                        target_hour_nxt_s = alarm_hour;
                        target_min_nxt_s  = alarm_min;
                    end else if (match_s) begin
                        state_nxt_s    = RINGING;
                        ring_cnt_nxt_s = 8'd0;
                    end else begin
                        state_nxt_s = SNOOZING;
                    end
                end
                default: begin
                    state_nxt_s      = DISARMED;
                    snooze_cnt_nxt_s = 4'd0;
                    ring_cnt_nxt_s   = 8'd0;
                end
            endcase
        end
    end

`ifdef ALARM_BEEP_PATTERN_EN
    logic beep_phase_r, beep_phase_nxt_s;

    // Beep phase starts high on ringing entry and flips every second while ringing.
    always_comb begin
        if (state_nxt_s != RINGING) begin
            beep_phase_nxt_s = 1'b0;
        end else if (state_r != RINGING) begin
            beep_phase_nxt_s = 1'b1;
        end else if (tick_1hz) begin
            beep_phase_nxt_s = ~beep_phase_r;
        end else begin
            beep_phase_nxt_s = beep_phase_r;
        end
    end

    // Beep phase register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beep_phase_r <= 1'b0;
        end else begin
            beep_phase_r <= beep_phase_nxt_s;
        end
    end

    assign buzz_nxt_s = (state_nxt_s == RINGING) & beep_phase_nxt_s;
`else
    assign buzz_nxt_s = (state_nxt_s == RINGING);
`endif

    // State, datapath and output registers; outputs are decoded from the next state so they track state_r.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r       <= DISARMED;
            target_hour_r <= 6'd0;
            target_min_r  <= 6'd0;
            snooze_cnt_r  <= 4'd0;
            ring_cnt_r    <= 8'd0;
            buzzer        <= 1'b0;
            armed_LED     <= 1'b0;
            snooze_LED    <= 1'b0;
            ringing       <= 1'b0;
            snooze_left   <= MAX_CNT;
        end else begin
            state_r       <= state_nxt_s;
            target_hour_r <= target_hour_nxt_s;
            target_min_r  <= target_min_nxt_s;
            snooze_cnt_r  <= snooze_cnt_nxt_s;
            ring_cnt_r    <= ring_cnt_nxt_s;
            buzzer        <= buzz_nxt_s;
            armed_LED     <= (state_nxt_s == ARMED) || (state_nxt_s == SNOOZING);
            snooze_LED    <= (state_nxt_s == SNOOZING);
            ringing       <= (state_nxt_s == RINGING);
            snooze_left   <= MAX_CNT - snooze_cnt_nxt_s;
        end
    end

endmodule

// File: tb/tb_alarm_ctrl.sv
// Directed self-checking bench for alarm_ctrl (SNOOZE_MIN=5, MAX_SNOOZE=3, RING_SEC=4).
module tb_alarm_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       tick_1hz;
    logic [5:0] cur_hour, cur_min, cur_sec;
    logic [5:0] alarm_hour, alarm_min;
    logic       switch_set, switch_alarm;
    logic       key_snooze, key_stop;
    logic       buzzer, armed_LED, snooze_LED, ringing;
    logic [3:0] snooze_left;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    alarm_ctrl #(.SNOOZE_MIN(5), .MAX_SNOOZE(3), .RING_SEC(4)) dut (
        .clk(clk), .rst_n(rst_n), .tick_1hz(tick_1hz),
        .cur_hour(cur_hour), .cur_min(cur_min), .cur_sec(cur_sec),
        .alarm_hour(alarm_hour), .alarm_min(alarm_min),
        .switch_set(switch_set), .switch_alarm(switch_alarm),
        .key_snooze(key_snooze), .key_stop(key_stop),
        .buzzer(buzzer), .armed_LED(armed_LED), .snooze_LED(snooze_LED),
        .ringing(ringing), .snooze_left(snooze_left)
    );

    task automatic check_val(input string tag, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic check_outs(input string tag, input int bz, input int arm,
                              input int snz, input int rng, input int left);
        check_val({tag, ".buzzer"},      int'(buzzer),      bz);
        check_val({tag, ".armed_LED"},   int'(armed_LED),   arm);
        check_val({tag, ".snooze_LED"},  int'(snooze_LED),  snz);
        check_val({tag, ".ringing"},     int'(ringing),     rng);
        check_val({tag, ".snooze_left"}, int'(snooze_left), left);
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set_time(input int h, input int m, input int s);
        cur_hour = 6'(h);
        cur_min  = 6'(m);
        cur_sec  = 6'(s);
    endtask

    task automatic tick_at(input int h, input int m, input int s);
        set_time(h, m, s);
        tick_1hz = 1'b1;
        step(1);
        tick_1hz = 1'b0;
    endtask

    task automatic press(input bit snz, input bit stp);
        key_snooze = snz ? 1'b0 : 1'b1;
        key_stop   = stp ? 1'b0 : 1'b1;
        step(3);
        key_snooze = 1'b1;
        key_stop   = 1'b1;
        step(3);
    endtask

    initial begin
        rst_n = 1'b0; tick_1hz = 1'b0;
        cur_hour = 6'd0; cur_min = 6'd0; cur_sec = 6'd0;
        alarm_hour = 6'd7; alarm_min = 6'd30;
        switch_set = 1'b0; switch_alarm = 1'b0;
        key_snooze = 1'b1; key_stop = 1'b1;
        #12;
        check_outs("reset", 0, 0, 0, 0, 3);
        @(negedge clk);
        rst_n = 1'b1;
        step(2);
        check_outs("disarmed", 0, 0, 0, 0, 3);

        // arm and ring at 07:30:00
        switch_alarm = 1'b1;
        step(2);
        check_outs("armed", 0, 1, 0, 0, 3);
        tick_at(7, 29, 59);
        check_val("pre_match.ringing", int'(ringing), 0);
        tick_at(7, 30, 0);
        check_outs("ring0730", 1, 0, 0, 1, 3);

        // stop latency: nothing changes until the third edge
        key_stop = 1'b0;
        step(2);
        check_val("stop_lat2.ringing", int'(ringing), 1);
        step(1);
        check_outs("stop_lat3", 0, 1, 0, 0, 3);
        key_stop = 1'b1;
        step(3);

        // snooze across midnight: 23:58 + 5 -> 00:03
        alarm_hour = 6'd23; alarm_min = 6'd58;
        step(1);
        tick_at(23, 58, 0);
        check_val("ring2358.ringing", int'(ringing), 1);
        set_time(23, 58, 30);
        press(1'b1, 1'b0);
        check_outs("snooze1", 0, 1, 1, 0, 2);
        tick_at(0, 2, 0);
        check_val("snz_early.ringing", int'(ringing), 0);
        tick_at(0, 3, 0);
        check_outs("snz1_ring", 1, 0, 0, 1, 2);

        // second and third snoozes without wrap
        set_time(0, 3, 10);
        press(1'b1, 1'b0);
        check_outs("snooze2", 0, 1, 1, 0, 1);
        tick_at(0, 8, 0);
        check_val("snz2_ring.ringing", int'(ringing), 1);
        set_time(0, 8, 20);
        press(1'b1, 1'b0);
        check_outs("snooze3", 0, 1, 1, 0, 0);
        tick_at(0, 13, 0);
        check_val("snz3_ring.ringing", int'(ringing), 1);
        set_time(0, 13, 30);
        press(1'b1, 1'b0);
        check_outs("snooze4_ignored", 1, 0, 0, 1, 0);
        press(1'b0, 1'b1);
        check_outs("stop_after_snz", 0, 1, 0, 0, 3);

        // ring timeout after 4 ticks, no retrigger at 07:31
        alarm_hour = 6'd7; alarm_min = 6'd30;
        step(1);
        tick_at(7, 30, 0);
        check_val("to_entry.buzzer", int'(buzzer), 1);
        tick_at(7, 30, 1);
`ifdef ALARM_BEEP_PATTERN_EN
        check_val("to_t1.buzzer", int'(buzzer), 0);
`else
        check_val("to_t1.buzzer", int'(buzzer), 1);
`endif
        tick_at(7, 30, 2);
        check_val("to_t2.buzzer", int'(buzzer), 1);
        tick_at(7, 30, 3);
        check_val("to_t3.ringing", int'(ringing), 1);
        tick_at(7, 30, 4);
        check_outs("timeout", 0, 1, 0, 0, 3);
        tick_at(7, 31, 0);
        check_val("no_retrig.ringing", int'(ringing), 0);

        // stop and snooze together -> stop wins
        alarm_hour = 6'd7; alarm_min = 6'd32;
        step(1);
        tick_at(7, 32, 0);
        check_val("both_pre.ringing", int'(ringing), 1);
        press(1'b1, 1'b1);
        check_outs("both_keys", 0, 1, 0, 0, 3);

        // switch_set override while ringing
        tick_at(7, 32, 0);
        check_val("ovr_pre.ringing", int'(ringing), 1);
        switch_set = 1'b1;
        step(1);
        check_outs("override", 0, 0, 0, 0, 3);
        switch_set = 1'b0;
        step(1);
        check_val("rearm.armed_LED", int'(armed_LED), 1);

        // async reset mid-snooze
        tick_at(7, 32, 0);
        set_time(7, 32, 5);
        press(1'b1, 1'b0);
        check_outs("pre_rst_snz", 0, 1, 1, 0, 2);
        #2 rst_n = 1'b0;
        #1;
        check_outs("async_rst", 0, 0, 0, 0, 3);
        @(negedge clk);
        rst_n = 1'b1;
        step(1);
        check_val("post_rst.armed_LED", int'(armed_LED), 1);

        // held snooze key yields a single press
        tick_at(7, 32, 0);
        set_time(7, 32, 5);
        key_snooze = 1'b0;
        step(3);
        check_outs("held_snz", 0, 1, 1, 0, 2);
        step(10);
        tick_at(7, 37, 0);
        step(5);
        check_outs("held_ring", 1, 0, 0, 1, 2);
        key_snooze = 1'b1;
        step(3);
        press(1'b0, 1'b1);
        check_outs("final_stop", 0, 1, 0, 0, 3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
